// File: rtl/simplebus_pkg.sv
// simplebus_pkg: shared types and constants for the simplebus follower
package simplebus_pkg;
  localparam int ADDR_WIDTH = 24;
  typedef logic [7:0] bus_byte_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_MID,
    S_ADDR_LO,
    S_READ_WAIT,
    S_WRITE_WAIT
  } simplebus_follower_state_t;
endpackage

// File: rtl/simplebus_mem_array.sv
// simplebus_mem_array: single-port byte memory, synchronous write, combinational read
module simplebus_mem_array
  import simplebus_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);
  bus_byte_t mem [2**ADDR_BITS];
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];
endmodule

// File: rtl/simplebus_mem_follower.sv
// simplebus_mem_follower: simplebus follower endpoint backed by a local byte memory
module simplebus_mem_follower
  import simplebus_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID    = 8'h01,
  parameter int         ADDR_BITS    = 16,
  parameter int         READ_LATENCY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       read,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       data_valid_in,
  output logic       data_valid_out,
  output logic       data_valid_oe
);
  simplebus_follower_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0] cnt_q;
  logic last_wait, mem_we;
  bus_byte_t mem_rdata;
  assign last_wait = cnt_q == 4'(READ_LATENCY);
  // a reset edge must never commit a pending write
  assign mem_we = state_q == S_WRITE_WAIT && data_valid_in && !reset;
  simplebus_mem_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clock(clock),
    .we(mem_we),
    .addr(addr_q[ADDR_BITS-1:0]),
    .wdata(data_in),
    .rdata(mem_rdata)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) addr_q[23:16] <= address;
      if (state_q == S_ADDR_MID) addr_q[15:8] <= address;
      if (state_q == S_ADDR_LO) addr_q[7:0] <= address;
      cnt_q <= (state_q == S_READ_WAIT && !last_wait) ? cnt_q + 4'd1 : 4'd0;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = start ? S_ADDR_MID : S_IDLE;
      S_ADDR_MID:   state_d = addr_q[23:16] == DEVICE_ID ? S_ADDR_LO : S_IDLE;
      S_ADDR_LO:    state_d = read ? S_READ_WAIT : S_WRITE_WAIT;
      S_READ_WAIT:  state_d = last_wait ? S_IDLE : S_READ_WAIT;
      S_WRITE_WAIT: state_d = data_valid_in ? S_IDLE : S_WRITE_WAIT;
      default:      state_d = S_IDLE;
    endcase
    data_valid_oe = state_q == S_READ_WAIT;
    data_valid_out = data_valid_oe && last_wait;
    data_oe = data_valid_out;
    data_out = data_oe ? mem_rdata : 8'h00;
  end
endmodule

// File: tb/tb_simplebus_mem_follower.sv
// tb_simplebus_mem_follower: directed and randomized bench against a byte-array memory model
module tb_simplebus_mem_follower;
  localparam int LAT = 2;
  logic clock = 1'b0;
  logic reset, start, read, data_valid_in;
  logic [7:0] address, data_in, data_out;
  logic data_oe, data_valid_out, data_valid_oe;
  logic [7:0] model [65536];
  int total = 0;
  int bad = 0;
  simplebus_mem_follower #(.DEVICE_ID(8'h01), .ADDR_BITS(16), .READ_LATENCY(LAT)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .read(read),
    .address(address),
    .data_in(data_in),
    .data_out(data_out),
    .data_oe(data_oe),
    .data_valid_in(data_valid_in),
    .data_valid_out(data_valid_out),
    .data_valid_oe(data_valid_oe)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic quiet(input string tag);
    chk(tag, {data_out, 5'b0, data_oe, data_valid_oe, data_valid_out}, 16'h0);
  endtask
  // address phase; a hit leaves the follower in its wait state, a miss in idle
  task automatic addr_hdr(input logic [7:0] id, input logic [15:0] a, input logic rd);
    start = 1'b1;
    address = id;
    read = 1'($urandom);
    step;
    start = 1'b0;
    quiet("mid");
    address = a[15:8];
    read = 1'($urandom);
    step;
    quiet(id == 8'h01 ? "lo" : "miss");
    address = a[7:0];
    read = rd;
    if (id != 8'h01) begin
      data_valid_in = 1'b1;
      data_in = 8'($urandom);
    end
    step;
    data_valid_in = 1'b0;
    if (id != 8'h01) quiet("miss_idle");
  endtask
  task automatic do_write(input logic [7:0] id, input logic [15:0] a, input logic [7:0] d, input int dly);
    addr_hdr(id, a, 1'b0);
    if (id != 8'h01) return;
    repeat (dly) begin
      quiet("wwait");
      data_in = 8'($urandom);
      start = 1'($urandom);
      step;
    end
    quiet("wstrobe");
    start = 1'b0;
    data_valid_in = 1'b1;
    data_in = d;
    step;
    data_valid_in = 1'b0;
    model[a] = d;
  endtask
  task automatic do_read(input logic [7:0] id, input logic [15:0] a);
    addr_hdr(id, a, 1'b1);
    if (id != 8'h01) return;
    for (int i = 0; i <= LAT; i++) begin
      chk("rd_vo", 16'(data_valid_oe), 16'h1);
      chk("rd_valid", 16'(data_valid_out), 16'(i == LAT));
      chk("rd_oe", 16'(data_oe), 16'(i == LAT));
      chk("rd_data", 16'(data_out), 16'(i == LAT ? model[a] : 8'h00));
      start = 1'($urandom);
      step;
    end
    start = 1'b0;
    quiet("rd_end");
  endtask
  initial begin
    logic [7:0] id, d;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) model[i] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    read = 1'b0;
    address = 8'h00;
    data_in = 8'h00;
    data_valid_in = 1'b0;
    step;
    step;
    quiet("reset");
    reset = 1'b0;
    do_write(8'h01, 16'h0406, 8'hDC, 0);
    do_write(8'h01, 16'h0407, 8'hAB, 0);
    do_read(8'h01, 16'h0406);
    do_read(8'h01, 16'h0407);
    do_write(8'h01, 16'h0406, 8'hF1, 0);
    do_read(8'h01, 16'h0406);
    do_write(8'h02, 16'h0406, 8'h55, 0);
    do_read(8'h01, 16'h0406);
    do_read(8'h01, 16'hBEEF);
    addr_hdr(8'h01, 16'h0406, 1'b1);
    chk("rst_rd_pre", 16'(data_valid_oe), 16'h1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    quiet("rst_rd");
    addr_hdr(8'h01, 16'h0407, 1'b0);
    reset = 1'b1;
    data_valid_in = 1'b1;
    data_in = 8'h99;
    step;
    reset = 1'b0;
    data_valid_in = 1'b0;
    quiet("rst_wr");
    do_read(8'h01, 16'h0407);
    do_write(8'h01, 16'h0500, 8'h3C, 5);
    do_read(8'h01, 16'h0500);
    do_write(8'h01, 16'h0501, 8'h7E, 0);
    do_read(8'h01, 16'h0501);
    for (int n = 0; n < 80; n++) begin
      id = $urandom_range(0, 3) == 0 ? 8'($urandom_range(2, 255)) : 8'h01;
      a = $urandom_range(0, 4) == 0 ? 16'($urandom) : 16'h0400 | 16'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(id, a, d, $urandom_range(0, 3));
      else do_read(id, a);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
